// File: rtl/ras_stack_pkg.sv
// Shared constants for the return-address-stack slice (control stage + storage).
package ras_stack_pkg;

  localparam int RAS_DEPTH = 8;
  localparam int PC_WIDTH  = 32;
  localparam logic [31:0] RAS_EMPTY_PC = 32'hFFFF_FFFF;

  // Opcodes the control stage decodes to generate push/pop requests.
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_SWAP = 2'd3
  } ras_op_e;

endpackage

// File: rtl/ras_stack_edge_detect.sv
// Rising-edge detector: turns a held request level into a single-cycle pulse.
module ras_stack_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic lvl,
  output logic pulse
);

  logic lvl_q;

  always_ff @(posedge clk) begin
    if (reset) lvl_q <= 1'b0;
    else       lvl_q <= lvl;
  end

  assign pulse = lvl & ~lvl_q;

endmodule

// File: rtl/ras_stack.sv
// Circular LIFO return-address stack; overflow drops the oldest entry.
// Optional RAS_STATS_EN adds saturating overflow/underflow event counters.
module ras_stack
  import ras_stack_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int WIDTH = PC_WIDTH,
  parameter logic [WIDTH-1:0] EMPTY_PC = RAS_EMPTY_PC
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             pc_in,
  output logic [WIDTH-1:0]             pc_out,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
`ifdef RAS_STATS_EN
  ,
  output logic [15:0]                  ovf_cnt,
  output logic [15:0]                  unf_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    tp;
  logic [PW-1:0]    tp_inc;
  logic [PW-1:0]    tp_dec;
  logic             do_push;
  logic             do_pop;
  ras_op_e          op;

  ras_stack_edge_detect u_push_edge (
    .clk   (clk),
    .reset (reset),
    .lvl   (push),
    .pulse (do_push)
  );

  ras_stack_edge_detect u_pop_edge (
    .clk   (clk),
    .reset (reset),
    .lvl   (pop),
    .pulse (do_pop)
  );

  always_comb begin
    op = OP_NONE;
    case ({do_push, do_pop})
      2'b10:   op = OP_PUSH;
      2'b01:   op = OP_POP;
      2'b11:   op = OP_SWAP;
      default: op = OP_NONE;
    endcase
  end

  assign tp_inc = tp + 1'b1;
  assign tp_dec = tp - 1'b1;
  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign pc_out = empty ? EMPTY_PC : mem[tp];

  // Storage is not reset; a swap on an empty stack degenerates to a push.
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      if (op == OP_PUSH || (op == OP_SWAP && empty)) mem[tp_inc] <= pc_in;
      else if (op == OP_SWAP)                         mem[tp]     <= pc_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      tp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      case (op)
        OP_PUSH: begin
          tp <= tp_inc;
          if (full) overflow <= 1'b1;
          else      count    <= count + 1'b1;
        end
        OP_POP: begin
          if (empty) begin
            underflow <= 1'b1;
          end else begin
            tp    <= tp_dec;
            count <= count - 1'b1;
          end
        end
        OP_SWAP: begin
          if (empty) begin
            tp    <= tp_inc;
            count <= CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RAS_STATS_EN
  // Counters survive flush so software can read totals across pipeline flushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_cnt <= '0;
      unf_cnt <= '0;
    end else begin
      if (overflow  && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 1'b1;
      if (underflow && unf_cnt != 16'hFFFF) unf_cnt <= unf_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ras_stack.sv
// Scoreboard bench for ras_stack: queue-based reference model, directed + random stimulus.
module tb_ras_stack;

  localparam int DEPTH = 8;
`ifdef RAS_STATS_EN
  localparam int EW = 72;
`else
  localparam int EW = 40;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] pc_out;
  logic        empty, full, overflow, underflow;
  logic [3:0]  count;
`ifdef RAS_STATS_EN
  logic [15:0] ovf_cnt, unf_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [EW-1:0] exp_q[$];

  // Reference model state: a plain queue of return addresses, newest at the back.
  logic [31:0] mq[$];
  bit          m_push_prev, m_pop_prev, m_ovf, m_unf;
  int unsigned m_ovf_cnt, m_unf_cnt;

  ras_stack dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .pc_in     (pc_in),
    .pc_out    (pc_out),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef RAS_STATS_EN
    ,
    .ovf_cnt   (ovf_cnt),
    .unf_cnt   (unf_cnt)
`endif
  );

  // Clock / reset block
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] pack_dut();
    logic [EW-1:0] v;
    v = '0;
    v[39:0] = {pc_out, count, empty, full, overflow, underflow};
`ifdef RAS_STATS_EN
    v[71:40] = {ovf_cnt, unf_cnt};
`endif
    return v;
  endfunction

  function automatic logic [EW-1:0] pack_model();
    logic [EW-1:0] v;
    logic [31:0]   top;
    int            n;
    n   = mq.size();
    top = (n > 0) ? mq[n-1] : 32'hFFFF_FFFF;
    v = '0;
    v[39:0] = {top, 4'(n), (n == 0), (n == DEPTH), m_ovf, m_unf};
`ifdef RAS_STATS_EN
    v[71:40] = {16'(m_ovf_cnt), 16'(m_unf_cnt)};
`endif
    return v;
  endfunction

  task automatic model_edge(input bit r, input bit f, input bit ps, input bit pp,
                            input logic [31:0] pc);
    bit dp, dq;
    if (r) begin
      mq.delete();
      m_push_prev = 0; m_pop_prev = 0;
      m_ovf = 0; m_unf = 0;
      m_ovf_cnt = 0; m_unf_cnt = 0;
      return;
    end
    // Event counters see the pulse that was visible before this edge.
    if (m_ovf && m_ovf_cnt < 16'hFFFF) m_ovf_cnt++;
    if (m_unf && m_unf_cnt < 16'hFFFF) m_unf_cnt++;
    dp = ps && !m_push_prev;
    dq = pp && !m_pop_prev;
    m_push_prev = ps;
    m_pop_prev  = pp;
    m_ovf = 0;
    m_unf = 0;
    if (f) begin
      mq.delete();
    end else if (dp && dq) begin
      if (mq.size() == 0) mq.push_back(pc);
      else                mq[mq.size()-1] = pc;
    end else if (dp) begin
      mq.push_back(pc);
      if (mq.size() > DEPTH) begin
        void'(mq.pop_front());
        m_ovf = 1;
      end
    end else if (dq) begin
      if (mq.size() == 0) m_unf = 1;
      else                void'(mq.pop_back());
    end
  endtask

  // Driver tasks
  task automatic step(input bit r, input bit f, input bit ps, input bit pp,
                      input logic [31:0] pc);
    @(negedge clk);
    reset = r; flush = f; push = ps; pop = pp; pc_in = pc;
    @(posedge clk);
    model_edge(r, f, ps, pp, pc);
    exp_q.push_back(pack_model());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'h0);
  endtask

  task automatic push_pulse(input logic [31:0] pc);
    step(0, 0, 1, 0, pc);
    step(0, 0, 0, 0, 32'h0);
  endtask

  task automatic pop_pulse();
    step(0, 0, 0, 1, 32'h0);
    step(0, 0, 0, 0, 32'h0);
  endtask

  // Monitor / scoreboard: outputs are compared every cycle on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] exp_v, act_v;
      exp_v = exp_q.pop_front();
      act_v = pack_dut();
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL state t=%0t: got pc_out=%h count=%0d empty=%b full=%b ovf=%b unf=%b (raw %h), expected pc_out=%h count=%0d empty=%b full=%b ovf=%b unf=%b (raw %h)",
                 $time, act_v[39:8], act_v[7:4], act_v[3], act_v[2], act_v[1], act_v[0], act_v,
                 exp_v[39:8], exp_v[7:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0], exp_v);
      end
    end
  end

  initial begin
    // 1: basic push/pop order
    step(1, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 32'h0);
    push_pulse(32'h100);
    push_pulse(32'h200);
    push_pulse(32'h300);
    pop_pulse(); pop_pulse(); pop_pulse();

    // 2: held push executes once
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 32'h40);
    idle(1);
    pop_pulse();

    // 3: overflow drops oldest entry
    for (int i = 1; i <= 9; i++) push_pulse(32'(i * 16));
    for (int i = 0; i < 9; i++) pop_pulse();

    // 4: underflow, then swap with two entries
    pop_pulse();
    push_pulse(32'h100);
    push_pulse(32'h200);
    step(0, 0, 1, 1, 32'h500);
    idle(1);
    // swap on an empty stack behaves as a push
    pop_pulse(); pop_pulse();
    step(0, 0, 1, 1, 32'h600);
    idle(1);

    // 5: flush while push is held, then reset coinciding with a push
    step(1, 0, 0, 0, 32'h0);
    for (int i = 0; i < 4; i++) push_pulse(32'hA00 + 32'(i));
    step(0, 0, 1, 0, 32'hB00);
    step(0, 1, 1, 0, 32'hB01);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 32'hB02);
    idle(1);
    push_pulse(32'hC00);
    step(1, 0, 1, 0, 32'hD00);
    idle(2);

    // 6: event counters across overflow, underflow, flush
    for (int i = 0; i < 11; i++) push_pulse(32'h1000 + 32'(i));
    step(0, 1, 0, 0, 32'h0);
    idle(1);
    pop_pulse(); pop_pulse();
    step(0, 1, 0, 0, 32'h0);
    idle(2);
    step(1, 0, 0, 0, 32'h0);
    idle(1);

    // Random: push-heavy phase then pop-heavy phase, occasional flush/reset
    for (int i = 0; i < 600; i++) begin
      bit r, f, ps, pp;
      r  = ($urandom_range(0, 149) == 0);
      f  = ($urandom_range(0, 59) == 0);
      ps = (i < 300) ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 25);
      pp = (i < 300) ? ($urandom_range(0, 99) < 25) : ($urandom_range(0, 99) < 60);
      step(r, f, ps, pp, $urandom);
    end
    idle(2);

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left unchecked, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ras_stack.md
Name: ras_stack

Overview:
Return address stack storage that sits directly downstream of the RAS control stage. It consumes that stage's push, pop, flush and return-PC outputs and supplies the predicted return PC back to it. Storage is a circular LIFO: overflow silently overwrites the oldest entry, and underflow returns a sentinel address. The control stage holds its request flags as levels, so this block acts once per request by detecting the rising edge of each flag.

Parameters:
DEPTH, 8, number of entries; power of two, at least 2.
WIDTH, 32, PC width in bits.
EMPTY_PC, 32'hFFFF_FFFF, value driven on pc_out when the stack is empty.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
flush  in  1  soft flush from the control stage's reset_outras output; synchronous, active-high.
push  in  1  push request level from the control stage.
pop  in  1  pop request level from the control stage.
pc_in  in  WIDTH  return address to push.
pc_out  out  WIDTH  current top of stack; combinational read of the registered top entry.
empty  out  1  count == 0.
full  out  1  count == DEPTH.
count  out  $clog2(DEPTH+1)  number of valid entries.
overflow  out  1  one-cycle pulse when a push overwrites the oldest entry.
underflow  out  1  one-cycle pulse when a pop occurs while the stack is empty.

Behaviour:
- Edge detection:
  - push_q and pop_q register the previous push and pop levels.
  - do_push = push & ~push_q; do_pop = pop & ~pop_q.
  - A level held high for N cycles produces exactly one operation.
- State: mem[DEPTH], top pointer tp of width $clog2(DEPTH), count. tp indexes the most recent entry. All pointer arithmetic is modulo DEPTH (natural wrap).
- pc_out: mem[tp] when count > 0, otherwise EMPTY_PC. The pre-operation top is visible in the same cycle the pop is requested. The post-operation value appears the cycle after the clock edge.
- Reset: count=0, tp=0, push_q=0, pop_q=0, overflow=0, underflow=0. Consequently pc_out=EMPTY_PC, empty=1, full=0. mem contents are not reset.
- Priority per edge: reset > flush > operation.
  - Flush: count=0, tp=0, overflow=0, underflow=0. push_q and pop_q still sample their inputs, so a held request is not re-executed after the flush.
- Operations, evaluated on edge-detected requests:
  - Push only: tp=tp+1, mem[tp+1]=pc_in.
    - If count<DEPTH: count=count+1.
    - If full: count unchanged, oldest entry lost, overflow=1 for one cycle.
  - Pop only:
    - If count>0: tp=tp-1, count=count-1.
    - If empty: no state change, underflow=1 for one cycle.
  - Push and pop in the same cycle (co-routine swap): mem[tp]=pc_in; tp and count unchanged.
    - If empty: behaves as push only (count=1) and no underflow pulse.
  - Neither: hold.
- overflow and underflow are registered; each is high only for the cycle after the triggering edge.
- Latency: one cycle from request edge to updated count/pc_out. There are no stalls; every request is accepted.

Optional Feature:
Macro RAS_STATS_EN.
- Defined: adds output ports ovf_cnt[15:0] and unf_cnt[15:0]. These are saturating counters incremented on each overflow or underflow pulse. They are cleared by reset only, not by flush, and saturate at 16'hFFFF.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package: RAS_DEPTH, PC_WIDTH, RAS_EMPTY_PC constants; the JAL/JALR opcode constants also used by the control stage.
- Sub-module edge_detect (one instance per request line): input lvl, output pulse, with synchronous reset clearing its register.
- Storage and pointer logic stay in ras_stack.

Test Plan:
1. Reset, then push pc_in=0x100, 0x200, 0x300 (one-cycle pulses) -> count=3, pc_out=0x300; pop x3 -> pc_out 0x200, 0x100, then EMPTY_PC with empty=1.
2. Push held high for 5 cycles with pc_in=0x40 -> exactly one push, count=1.
3. DEPTH=8: push 0x10..0x90 (9 pushes) -> overflow pulses once on the 9th, count=8, full=1; 8 pops return 0x90..0x20, then empty.
4. Pop while empty -> underflow pulses for one cycle, count=0, pc_out=0xFFFF_FFFF. Simultaneous push 0x500 + pop with count=2, top=0x200 -> count=2, pc_out=0x500.
5. Flush with count=4 while push is held high -> count=0, empty=1; push is not re-executed until it drops and rises again. Reset asserted in the same cycle as a push -> push discarded, count=0.
6. With RAS_STATS_EN defined: 3 overflows and 2 underflows -> ovf_cnt=3, unf_cnt=2; flush leaves both counters unchanged; reset clears both to 0.
